itlb_ctrl: RTL and testbench

Lookup and refill controller for the instruction TLB CAM array: it sequences NUM_ENTRIES itlb CAM lines and sits between instruction fetch and the page-table walker (PTW). On a lookup it resolves hit/miss from the per-line hit vector. On a miss it holds fetch off, issues a PTW request, and writes the returned translation into a victim line. It also distributes sfence.vma flushes to all lines and keeps an outstanding walk consistent across a flush.

---
 rtl/itlb_ctrl.sv | 98 +++++++++
 tb/tb_itlb_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itlb_ctrl.sv
// itlb_ctrl: ITLB lookup/refill controller between fetch, the CAM lines and the page-table walker
module itlb_ctrl #(
    parameter int NUM_ENTRIES = 8,
    parameter int ASID_WD     = 9,
    parameter int VPN_WD      = 20,
    localparam int IW         = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   lookup_valid_i,
    input  logic [VPN_WD-1:0]      lookup_vpn_i,
    input  logic [ASID_WD-1:0]     lookup_asid_i,
    output logic                   lookup_ready_o,
    input  logic [NUM_ENTRIES-1:0] line_hit_i,
    input  logic [NUM_ENTRIES-1:0] line_valid_i,
    output logic [VPN_WD-1:0]      line_vpn_o,
    output logic [ASID_WD-1:0]     line_asid_o,
    output logic [NUM_ENTRIES-1:0] line_we_o,
    output logic                   line_flush_o,
    output logic                   hit_o,
    output logic [IW-1:0]          hit_idx_o,
    output logic                   miss_o,
    output logic                   ptw_req_valid_o,
    input  logic                   ptw_req_ready_i,
    output logic [VPN_WD-1:0]      ptw_req_vpn_o,
    output logic [ASID_WD-1:0]     ptw_req_asid_o,
    input  logic                   ptw_rsp_valid_i,
    input  logic                   ptw_rsp_fault_i,
    output logic                   fault_o,
    input  logic                   flush_i,
    output logic                   busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_REFILL, S_DRAIN} state_e;
    state_e               state_q, state_d;
    logic [VPN_WD-1:0]    miss_vpn_q, miss_vpn_d;
    logic [ASID_WD-1:0]   miss_asid_q, miss_asid_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        hit_lsb, victim;
    logic                 in_idle, accept;

    assign in_idle         = state_q == S_IDLE;
    assign lookup_ready_o  = in_idle & ~flush_i;
    assign accept          = lookup_valid_i & lookup_ready_o;
    assign hit_o           = accept & |line_hit_i;
    assign miss_o          = accept & ~|line_hit_i;
    assign hit_idx_o       = hit_o ? hit_lsb : '0;
    assign line_vpn_o      = in_idle ? lookup_vpn_i : miss_vpn_q;
    assign line_asid_o     = in_idle ? lookup_asid_i : miss_asid_q;
    assign line_we_o       = (state_q == S_REFILL && !flush_i) ? NUM_ENTRIES'(1) << victim : '0;
    assign line_flush_o    = flush_i;
    assign ptw_req_valid_o = state_q == S_REQ;
    assign ptw_req_vpn_o   = miss_vpn_q;
    assign ptw_req_asid_o  = miss_asid_q;
    assign fault_o         = state_q == S_WAIT && ptw_rsp_valid_i && ptw_rsp_fault_i && !flush_i;
    assign busy_o          = ~in_idle;

    // lowest hitting line wins; victim is the lowest free line, else the round-robin pointer
    always_comb begin
        hit_lsb = '0;
        victim  = rr_q;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (line_hit_i[i]) hit_lsb = IW'(i);
            if (!line_valid_i[i]) victim = IW'(i);
        end
    end

    // next-state, miss capture and round-robin advance (only on a full-array refill)
    always_comb begin
        miss_vpn_d  = miss_o ? lookup_vpn_i : miss_vpn_q;
        miss_asid_d = miss_o ? lookup_asid_i : miss_asid_q;
        rr_d        = flush_i ? '0 : (state_q == S_REFILL && &line_valid_i) ? rr_q + 1'b1 : rr_q;
        case (state_q)
            S_IDLE:   state_d = miss_o ? S_REQ : S_IDLE;
            S_REQ:    state_d = flush_i ? (ptw_req_ready_i ? S_DRAIN : S_IDLE)
                                        : (ptw_req_ready_i ? S_WAIT : S_REQ);
            S_WAIT:   state_d = ptw_rsp_valid_i ? ((flush_i || ptw_rsp_fault_i) ? S_IDLE : S_REFILL)
                                                : (flush_i ? S_DRAIN : S_WAIT);
            S_REFILL: state_d = S_IDLE;
            S_DRAIN:  state_d = ptw_rsp_valid_i ? S_IDLE : S_DRAIN;
            default:  state_d = S_IDLE;
        endcase
    end

    // state and miss registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            miss_vpn_q  <= '0;
            miss_asid_q <= '0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            miss_vpn_q  <= miss_vpn_d;
            miss_asid_q <= miss_asid_d;
            rr_q        <= rr_d;
        end
    end
endmodule

// File: tb/tb_itlb_ctrl.sv
// tb_itlb_ctrl: scenario and randomized checks of itlb_ctrl against a victim-selection model
module tb_itlb_ctrl;
    localparam int N = 8, AW = 9, VW = 20, IW = 3;
    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          lookup_valid_i;
    logic [VW-1:0] lookup_vpn_i;
    logic [AW-1:0] lookup_asid_i;
    logic          lookup_ready_o;
    logic [N-1:0]  line_hit_i, line_valid_i, line_we_o;
    logic [VW-1:0] line_vpn_o, ptw_req_vpn_o;
    logic [AW-1:0] line_asid_o, ptw_req_asid_o;
    logic          line_flush_o, hit_o, miss_o, ptw_req_valid_o, ptw_req_ready_i;
    logic [IW-1:0] hit_idx_o;
    logic          ptw_rsp_valid_i, ptw_rsp_fault_i, fault_o, flush_i, busy_o;
    int            checks = 0, errors = 0;
    int            rr_m = 0;

    itlb_ctrl #(.NUM_ENTRIES(N), .ASID_WD(AW), .VPN_WD(VW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .lookup_valid_i(lookup_valid_i), .lookup_vpn_i(lookup_vpn_i), .lookup_asid_i(lookup_asid_i),
        .lookup_ready_o(lookup_ready_o), .line_hit_i(line_hit_i), .line_valid_i(line_valid_i),
        .line_vpn_o(line_vpn_o), .line_asid_o(line_asid_o), .line_we_o(line_we_o),
        .line_flush_o(line_flush_o), .hit_o(hit_o), .hit_idx_o(hit_idx_o), .miss_o(miss_o),
        .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
        .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_asid_o(ptw_req_asid_o),
        .ptw_rsp_valid_i(ptw_rsp_valid_i), .ptw_rsp_fault_i(ptw_rsp_fault_i), .fault_o(fault_o),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // model: first invalid line, else round-robin slot which then advances
    task automatic model_refill(input logic [N-1:0] v, output logic [N-1:0] we);
        int idx;
        idx = -1;
        for (int i = 0; i < N; i++) if (!v[i] && idx < 0) idx = i;
        if (idx < 0) begin
            idx  = rr_m;
            rr_m = (rr_m + 1) % N;
        end
        we = '0;
        we[idx] = 1'b1;
    endtask

    task automatic start_miss(input logic [VW-1:0] vpn, input logic [AW-1:0] asid, input logic [N-1:0] v);
        lookup_valid_i = 1'b1; lookup_vpn_i = vpn; lookup_asid_i = asid;
        line_hit_i = '0; line_valid_i = v;
        #1;
        checks++;
        if (miss_o !== 1'b1 || hit_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_pulse: miss_o=%b hit_o=%b, required 1/0", miss_o, hit_o);
        end
        tick();
        lookup_valid_i = 1'b0;
    endtask

    task automatic run_walk(input logic [VW-1:0] vpn, input logic [AW-1:0] asid, input logic [N-1:0] v,
                            input int rq, input int rs, input logic flt);
        logic [N-1:0] exp_we;
        start_miss(vpn, asid, v);
        for (int k = 0; k <= rq; k++) begin
            ptw_req_ready_i = (k == rq);
            #1;
            checks++;
            if (ptw_req_valid_o !== 1'b1 || ptw_req_vpn_o !== vpn || ptw_req_asid_o !== asid) begin
                errors++;
                $display("FAIL req_fields: valid=%b vpn=%h asid=%h, required 1 %h %h",
                         ptw_req_valid_o, ptw_req_vpn_o, ptw_req_asid_o, vpn, asid);
            end
            tick();
        end
        ptw_req_ready_i = 1'b0;
        for (int k = 0; k < rs; k++) begin
            #1;
            checks++;
            if (busy_o !== 1'b1 || fault_o !== 1'b0 || line_we_o !== '0 || ptw_req_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL wait_state: busy=%b fault=%b we=%h req=%b, required 1 0 00 0",
                         busy_o, fault_o, line_we_o, ptw_req_valid_o);
            end
            tick();
        end
        ptw_rsp_valid_i = 1'b1; ptw_rsp_fault_i = flt;
        #1;
        checks++;
        if (fault_o !== flt || line_we_o !== '0) begin
            errors++;
            $display("FAIL rsp_cycle: fault=%b we=%h, required %b 00", fault_o, line_we_o, flt);
        end
        tick();
        ptw_rsp_valid_i = 1'b0; ptw_rsp_fault_i = 1'b0;
        if (!flt) begin
            model_refill(v, exp_we);
            #1;
            checks++;
            if (line_we_o !== exp_we || line_vpn_o !== vpn || line_asid_o !== asid) begin
                errors++;
                $display("FAIL refill: we=%h vpn=%h asid=%h, required %h %h %h",
                         line_we_o, line_vpn_o, line_asid_o, exp_we, vpn, asid);
            end
            tick();
        end
        #1;
        checks++;
        if (busy_o !== 1'b0 || fault_o !== 1'b0 || line_we_o !== '0 || lookup_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL back_idle: busy=%b fault=%b we=%h ready=%b, required 0 0 00 1",
                     busy_o, fault_o, line_we_o, lookup_ready_o);
        end
    endtask

    task automatic test_reset;
        rstn_i = 1'b0; lookup_valid_i = 0; lookup_vpn_i = 0; lookup_asid_i = 0;
        line_hit_i = 0; line_valid_i = 0; ptw_req_ready_i = 0; ptw_rsp_valid_i = 0;
        ptw_rsp_fault_i = 0; flush_i = 0;
        #1;
        checks++;
        if (lookup_ready_o !== 1'b1 || {line_vpn_o, line_asid_o, line_we_o, line_flush_o, hit_o, hit_idx_o,
            miss_o, ptw_req_valid_o, ptw_req_vpn_o, ptw_req_asid_o, fault_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%h req=%b busy=%b fault=%b, required 1 and all zero",
                     lookup_ready_o, line_we_o, ptw_req_valid_o, busy_o, fault_o);
        end
        tick();
        rstn_i = 1'b1;
        tick();
        start_miss(20'h004FF, 9'd2, 8'h00);
        #1;
        checks++;
        if (busy_o !== 1'b1 || ptw_req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL req_after_miss: busy=%b req=%b, required 1 1", busy_o, ptw_req_valid_o);
        end
        rstn_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ptw_req_valid_o !== 1'b0 || ptw_req_vpn_o !== '0) begin
            errors++;
            $display("FAIL reset_midwalk: busy=%b req=%b vpn=%h, required 0 0 00000",
                     busy_o, ptw_req_valid_o, ptw_req_vpn_o);
        end
        tick();
        rstn_i = 1'b1;
        rr_m = 0;
        tick();
        ptw_rsp_valid_i = 1'b1; ptw_rsp_fault_i = 1'b1;
        #1;
        checks++;
        if (fault_o !== 1'b0 || line_we_o !== '0) begin
            errors++;
            $display("FAIL stray_rsp: fault=%b we=%h, required 0 00", fault_o, line_we_o);
        end
        tick();
        ptw_rsp_valid_i = 1'b0; ptw_rsp_fault_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_rsp_idle: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_miss_refill;
        run_walk(20'h004FF, 9'd2, 8'h00, 2, 3, 1'b0);
        tick();
        lookup_valid_i = 1'b1; line_hit_i = 8'h01; line_valid_i = 8'h01;
        #1;
        checks++;
        if (hit_o !== 1'b1 || hit_idx_o !== 3'd0 || miss_o !== 1'b0) begin
            errors++;
            $display("FAIL relookup_hit: hit=%b idx=%0d miss=%b, required 1 0 0", hit_o, hit_idx_o, miss_o);
        end
        tick();
        lookup_valid_i = 1'b0; line_hit_i = '0;
    endtask

    task automatic test_round_robin;
        for (int k = 0; k < 4; k++) begin
            tick();
            run_walk(VW'($urandom), AW'($urandom), 8'hFF, 0, 1, 1'b0);
        end
        tick();
        flush_i = 1'b1; lookup_valid_i = 1'b1; line_hit_i = '0;
        #1;
        checks++;
        if (line_flush_o !== 1'b1 || lookup_ready_o !== 1'b0 || miss_o !== 1'b0 || hit_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush: flush=%b ready=%b miss=%b hit=%b, required 1 0 0 0",
                     line_flush_o, lookup_ready_o, miss_o, hit_o);
        end
        tick();
        flush_i = 1'b0; lookup_valid_i = 1'b0;
        rr_m = 0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || line_flush_o !== 1'b0) begin
            errors++;
            $display("FAIL after_flush: busy=%b flush=%b, required 0 0", busy_o, line_flush_o);
        end
        run_walk(20'h12345, 9'd7, 8'hFF, 1, 0, 1'b0);
    endtask

    task automatic test_invalid_first;
        tick();
        run_walk(20'h0ABCD, 9'd3, 8'hF7, 0, 0, 1'b0);
        tick();
        run_walk(20'h0ABCE, 9'd3, 8'hFF, 0, 0, 1'b0);
    endtask

    task automatic test_fault;
        tick();
        run_walk(20'h0F00D, 9'd5, 8'h3F, 1, 2, 1'b1);
    endtask

    task automatic test_flush_wait;
        tick();
        start_miss(20'h00111, 9'd1, 8'hFF);
        ptw_req_ready_i = 1'b1;
        tick();
        ptw_req_ready_i = 1'b0; flush_i = 1'b1;
        #1;
        checks++;
        if (line_flush_o !== 1'b1 || fault_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: flush=%b fault=%b busy=%b, required 1 0 1", line_flush_o, fault_o, busy_o);
        end
        tick();
        flush_i = 1'b0; rr_m = 0;
        #1;
        checks++;
        if (busy_o !== 1'b1 || lookup_ready_o !== 1'b0 || ptw_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy=%b ready=%b req=%b, required 1 0 0", busy_o, lookup_ready_o, ptw_req_valid_o);
        end
        tick();
        tick();
        ptw_rsp_valid_i = 1'b1;
        #1;
        checks++;
        if (line_we_o !== '0 || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_rsp: we=%h fault=%b, required 00 0", line_we_o, fault_o);
        end
        tick();
        ptw_rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || line_we_o !== '0) begin
            errors++;
            $display("FAIL drain_exit: busy=%b we=%h, required 0 00", busy_o, line_we_o);
        end
    endtask

    task automatic test_flush_req;
        tick();
        start_miss(20'h00222, 9'd4, 8'h00);
        flush_i = 1'b1;
        #1;
        checks++;
        if (ptw_req_valid_o !== 1'b1 || line_flush_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_req: req=%b flush=%b, required 1 1", ptw_req_valid_o, line_flush_o);
        end
        tick();
        flush_i = 1'b0; rr_m = 0;
        #1;
        checks++;
        if (ptw_req_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_drop: req=%b busy=%b, required 0 0", ptw_req_valid_o, busy_o);
        end
    endtask

    task automatic test_flush_rsp;
        tick();
        start_miss(20'h00333, 9'd6, 8'h00);
        ptw_req_ready_i = 1'b1;
        tick();
        ptw_req_ready_i = 1'b0; flush_i = 1'b1; ptw_rsp_valid_i = 1'b1; ptw_rsp_fault_i = 1'b1;
        #1;
        checks++;
        if (fault_o !== 1'b0 || line_we_o !== '0) begin
            errors++;
            $display("FAIL flush_rsp: fault=%b we=%h, required 0 00", fault_o, line_we_o);
        end
        tick();
        flush_i = 1'b0; ptw_rsp_valid_i = 1'b0; ptw_rsp_fault_i = 1'b0; rr_m = 0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || line_we_o !== '0) begin
            errors++;
            $display("FAIL flush_rsp_idle: busy=%b we=%h, required 0 00", busy_o, line_we_o);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                logic [N-1:0] h;
                int exp_idx;
                h = N'($urandom_range(1, 255));
                exp_idx = 0;
                for (int i = N - 1; i >= 0; i--) if (h[i]) exp_idx = i;
                lookup_valid_i = 1'b1; line_hit_i = h; lookup_vpn_i = VW'($urandom);
                #1;
                checks++;
                if (hit_o !== 1'b1 || hit_idx_o !== IW'(exp_idx) || miss_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_hit: hits=%h hit=%b idx=%0d, required 1 %0d", h, hit_o, hit_idx_o, exp_idx);
                end
                tick();
                lookup_valid_i = 1'b0; line_hit_i = '0;
            end else begin
                run_walk(VW'($urandom), AW'($urandom), $urandom_range(0, 1) ? 8'hFF : N'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_refill();
        test_round_robin();
        test_invalid_first();
        test_fault();
        test_flush_wait();
        test_flush_req();
        test_flush_rsp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
